// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO pointer/flag controller.
//   op_e  : decode of the {wr, rd} request pair
//   depth : number of entries for a given address width
package fifo_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  function automatic int unsigned depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller that turns an external reg_file into a
// synchronous FIFO. It generates the write strobe and both addresses, and
// tracks fill level, full/empty and sticky overflow/underflow flags.
//
// Optional feature macro: FIFO_ALMOST_FLAGS_EN (adds almost_full/almost_empty).
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   wr           in   push request (data goes straight into reg_file)
//   rd           in   pop request (entry at r_addr is consumed)
//   clear_err    in   pulse clearing the sticky error flags
//   wr_en        out  combinational write strobe to reg_file
//   w_addr       out  registered write pointer
//   r_addr       out  registered read pointer; r_data valid while empty=0
//   full, empty  out  registered status flags
//   level        out  registered entry count, 0..2**ADDR_WIDTH
//   overflow     out  sticky: push attempted while full (without a pop)
//   underflow    out  sticky: pop attempted while empty
//   almost_full  out  level >= AF_THRESH   (FIFO_ALMOST_FLAGS_EN only)
//   almost_empty out  level <= AE_THRESH   (FIFO_ALMOST_FLAGS_EN only)
//
// Request semantics: wr and rd are sampled on every rising edge with no
// ready handshake. A request that cannot be served (push while full with no
// pop, pop while empty) is dropped and recorded in the matching sticky flag.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clear_err,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
`ifdef FIFO_ALMOST_FLAGS_EN
  output logic                  almost_full,
  output logic                  almost_empty,
`endif
  output logic                  underflow
);

  localparam int unsigned         DEPTH   = depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LVL_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic do_push, do_pop, ovf_set, unf_set;
  op_e  op;

  assign op = op_e'({wr, rd});

  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      OP_PUSH: begin
        if (!full_q) do_push = 1'b1;
        else         ovf_set = 1'b1;
      end
      OP_POP: begin
        if (!empty_q) do_pop  = 1'b1;
        else          unf_set = 1'b1;
      end
      OP_BOTH: begin
        // Empty: only the write happens, so the read never sees an unwritten
        // slot. Full: the pop frees the slot the push needs, so both proceed.
        do_push = 1'b1;
        if (empty_q) unf_set = 1'b1;
        else         do_pop  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_addr_d = do_push ? w_addr_q + PTR_ONE : w_addr_q;
    r_addr_d = do_pop  ? r_addr_q + PTR_ONE : r_addr_q;
    level_d  = level_q;
    if (do_push && !do_pop)      level_d = level_q + LVL_ONE;
    else if (do_pop && !do_push) level_d = level_q - LVL_ONE;
    full_d      = (level_d == DEPTH_L);
    empty_d     = (level_d == '0);
    // A new error on the same edge as clear_err wins.
    overflow_d  = ovf_set | (overflow_q  & ~clear_err);
    underflow_d = unf_set | (underflow_q & ~clear_err);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_addr_q    <= '0;
      r_addr_q    <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_addr_q    <= w_addr_d;
      r_addr_q    <= r_addr_d;
      level_q     <= level_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [ADDR_WIDTH:0] AF_L = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_L = AE_THRESH[ADDR_WIDTH:0];

  logic almost_full_q, almost_empty_q;

  // Computed from next-state level so the flags change together with level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (level_d >= AF_L);
      almost_empty_q <= (level_d <= AE_L);
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

  assign wr_en     = do_push;
  assign w_addr    = w_addr_q;
  assign r_addr    = r_addr_q;
  assign level     = level_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl: a small reg_file stand-in stores data at w_addr on
// wr_en and presents mem[r_addr] as r_data. A queue-based FIFO model predicts
// every output; directed steps are followed by a random phase.
module tb_fifo_ctrl;

  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic          clear_err = 1'b0;
  logic          wr_en;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          underflow;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic          almost_full;
  logic          almost_empty;
`endif

  logic [7:0] wdata = 8'h00;
  logic [7:0] mem [DEPTH];
  logic [7:0] r_data;

  // scoreboard / model state
  logic [7:0] exp_q[$];
  int         wcnt = 0;
  int         rcnt = 0;
  logic       ovf_m = 1'b0;
  logic       unf_m = 1'b0;
  int         total = 0;
  int         bad = 0;

  fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr        (wr),
    .rd        (rd),
    .clear_err (clear_err),
    .wr_en     (wr_en),
    .w_addr    (w_addr),
    .r_addr    (r_addr),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
`ifdef FIFO_ALMOST_FLAGS_EN
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`endif
    .underflow (underflow)
  );

  // clock
  always #5 clk = ~clk;

  // reg_file stand-in
  always_ff @(posedge clk) begin
    if (wr_en) mem[w_addr] <= wdata;
  end
  assign r_data = mem[r_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int sz;
    sz = exp_q.size();
    chk("w_addr",    32'(w_addr),    32'(wcnt % DEPTH));
    chk("r_addr",    32'(r_addr),    32'(rcnt % DEPTH));
    chk("level",     32'(level),     32'(sz));
    chk("full",      32'(full),      32'(sz == DEPTH));
    chk("empty",     32'(empty),     32'(sz == 0));
    chk("overflow",  32'(overflow),  32'(ovf_m));
    chk("underflow", 32'(underflow), 32'(unf_m));
`ifdef FIFO_ALMOST_FLAGS_EN
    chk("almost_full",  32'(almost_full),  32'(sz >= DEPTH - 1));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= 1));
`endif
  endtask

  // One clock of requests: drive after the falling edge, check the
  // combinational strobe and read data, then check registered state after
  // the rising edge.
  task automatic cycle(input logic w, input logic r, input logic c, input logic [7:0] d);
    int   sz;
    logic push_ok, pop_ok, new_ovf, new_unf;
    @(negedge clk);
    wr = w; rd = r; clear_err = c; wdata = d;
    #1;
    sz      = exp_q.size();
    push_ok = w && (sz < DEPTH || r);
    pop_ok  = r && (sz > 0);
    new_ovf = w && !r && (sz == DEPTH);
    new_unf = r && (sz == 0);
    chk("wr_en", 32'(wr_en), 32'(push_ok));
    if (sz > 0) chk("r_data", 32'(r_data), 32'(exp_q[0]));
    @(posedge clk);
    ovf_m = new_ovf | (ovf_m & ~c);
    unf_m = new_unf | (unf_m & ~c);
    if (pop_ok) begin
      void'(exp_q.pop_front());
      rcnt++;
    end
    if (push_ok) begin
      exp_q.push_back(d);
      wcnt++;
    end
    #1;
    check_state();
  endtask

  task automatic model_reset();
    exp_q.delete();
    wcnt = 0; rcnt = 0;
    ovf_m = 1'b0; unf_m = 1'b0;
  endtask

  // Assert reset between clock edges and check that outputs clear at once.
  task automatic async_reset();
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; clear_err = 1'b0;
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_state();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    // reset held from time 0
    #13;
    model_reset();
    check_state();
    @(negedge clk);
    reset_n = 1'b1;

    // idle
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);

    // fill with F0..F7, then one push too many
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 8'hF0 + 8'(i));
    cycle(1'b1, 1'b0, 1'b0, 8'hEE);

    // drain in order, then one pop too many, then clear errors
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);

    // wrap: push 5, pop 5, push 6 from a fresh reset
    async_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 8'(i + 8'h10));
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 8'(i + 8'h20));
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

    // simultaneous push/pop when full, then when empty
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 8'(i + 8'h30));
    cycle(1'b1, 1'b1, 1'b0, 8'h5A);
    cycle(1'b1, 1'b1, 1'b0, 8'h5B);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 8'h6C);

    // error set on the same edge as clear_err: set wins
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0), 8'($urandom));
    end

    // asynchronous reset in the middle of traffic at level 4
    async_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
    async_reset();
    cycle(1'b0, 1'b0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Pointer/flag controller that drives the write and read ports of reg_file, so the pair forms a synchronous FIFO. It accepts push (wr) and pop (rd) requests from the client, generates w_addr, r_addr and a gated wr_en for reg_file, and reports full, empty, fill level and sticky error flags. It is the address-generating initiator side of reg_file.

Parameters:
ADDR_WIDTH, 3, address bits; depth is 2**ADDR_WIDTH entries; must match reg_file ADDR_WIDTH.
AF_THRESH, 2**ADDR_WIDTH-1, almost_full asserts when level >= AF_THRESH (used only with the optional feature).
AE_THRESH, 1, almost_empty asserts when level <= AE_THRESH (used only with the optional feature).

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
wr  in  1  push request; data accompanies it directly into reg_file.
rd  in  1  pop request; the entry at r_addr is consumed.
clear_err  in  1  single-cycle pulse that clears sticky error flags.
wr_en  out  1  write strobe to reg_file; wr & ~full, or wr & full & rd (see below); combinational.
w_addr  out  ADDR_WIDTH  write pointer to reg_file; registered.
r_addr  out  ADDR_WIDTH  read pointer to reg_file; registered; r_data is valid whenever empty=0.
full  out  1  registered.
empty  out  1  registered.
level  out  ADDR_WIDTH+1  entry count, 0..2**ADDR_WIDTH; registered.
overflow  out  1  sticky; registered.
underflow  out  1  sticky; registered.
almost_full, almost_empty  out  1 each  present only with FIFO_ALMOST_FLAGS_EN.

Behaviour:
- Reset (async, reset_n=0): w_addr=0, r_addr=0, level=0, empty=1, full=0, overflow=0, underflow=0, almost_empty=1, almost_full=0. Deassertion takes effect at the next rising clk.
- All state updates on rising clk edges; flags reflect the new state one cycle after the request.
- Decode on {wr,rd}, evaluated each edge:
  - 00: hold.
  - 10 (push): if ~full, w_addr+1, level+1, empty<=0, full<=(level+1 == 2**ADDR_WIDTH). If full, push is dropped, wr_en=0, overflow<=1.
  - 01 (pop): if ~empty, r_addr+1, level-1, full<=0, empty<=(level-1 == 0). If empty, pop is ignored, underflow<=1.
  - 11 when neither full nor empty: both pointers +1, level, full and empty unchanged.
  - 11 when empty: write only (behaves as 10), underflow<=1; read data is never taken from an unwritten slot.
  - 11 when full: both pointers +1 and wr_en=1; level stays at 2**ADDR_WIDTH and full stays 1; no overflow.
- Pointers wrap modulo 2**ADDR_WIDTH naturally (7+1 -> 0 at ADDR_WIDTH=3).
- full and empty are never asserted together; level==0 <=> empty, level==2**ADDR_WIDTH <=> full.
- Sticky errors: clear_err resets them to 0 on the edge; if a new error occurs on the same edge as clear_err, the set wins.
- Single state register set: no FSM beyond pointers/flags; all next-state logic is combinational and all outputs except wr_en are registered.

Optional Feature:
FIFO_ALMOST_FLAGS_EN: when defined, adds almost_full (level >= AF_THRESH) and almost_empty (level <= AE_THRESH) as registered outputs, computed from next-state level so they align with level. When undefined, neither the ports nor the logic exist, and the thresholds are unused.

Decomposition:
- Shared package fifo_pkg: op_e enum {OP_NOP, OP_POP, OP_PUSH, OP_BOTH} for {wr,rd} decode; function depth(addr_width).
- No sub-module is required. The future top fifo (fifo_ctrl + reg_file) lives outside this block.

Test Plan:
- Reset, then idle 3 cycles -> empty=1, full=0, level=0, w_addr=r_addr=0, errors=0.
- 8 pushes of 8'hF0..8'hF7 (ADDR_WIDTH=3) -> level 1..8, full=1 after 8th, empty=0; 9th push -> wr_en=0, w_addr stays 0, overflow=1.
- From full, 8 pops -> r_data F0..F7 in order, empty=1 after 8th; extra pop -> underflow=1, r_addr stays 0; clear_err pulse -> both errors 0.
- Wrap: push 5, pop 5, push 6 -> w_addr goes 5->7->0->3, level=6, data order preserved across the wrap.
- Simultaneous wr&rd when full -> level stays 8, both pointers +1, overflow stays 0; when empty -> level=1, underflow=1.
- Assert reset_n=0 mid-stream at level=4 -> all outputs return to reset values immediately, without waiting for a clk edge; with FIFO_ALMOST_FLAGS_EN, AF=7/AE=1 -> almost_full at level 7, almost_empty at level <=1.
